// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
// Provides the controller state encoding, digit widths and the add-3 correction constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ITERS   = 8;
    localparam int DIGIT_W = 4;
    localparam int HUND_W  = 2;
    localparam int BCD_W   = HUND_W + 2 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] CORR_OFFSET = 4'd3;

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// rtl/bcd_seq_ctrl_if.sv - request/result handshake bundle for bcd_seq_ctrl
// Ports: in_valid/in_ready/in_data (request), out_valid/out_ready/ONES/TENS/HUNDREDS (result), busy.
// master: requester/consumer side; slave: converter side.
interface bcd_seq_ctrl_if;
    import bcd_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic               out_valid;
    logic               out_ready;
    logic [DIGIT_W-1:0] ONES;
    logic [DIGIT_W-1:0] TENS;
    logic [HUND_W-1:0]  HUNDREDS;
    logic               busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, ONES, TENS, HUNDREDS, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, ONES, TENS, HUNDREDS, busy
    );

endinterface

// File: rtl/bcd_seq_ctrl_bcd3.sv
// rtl/bcd_seq_ctrl_bcd3.sv - add-3 correction cell for one BCD digit
// Ports: din (digit before shift), dout (din + 3 when din >= 5, else din).
module bcd3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Inputs are always 0..9 here, so din + 3 never exceeds 12 and cannot wrap.
    assign dout = (din >= CORR_THRESH) ? (din + CORR_OFFSET) : din;

endmodule

// File: rtl/bcd_seq_ctrl.sv
// rtl/bcd_seq_ctrl.sv - sequential double-dabble controller, one bit per clock
// Ports: clk, rst (sync, active-high), bus (slave): accepts an 8-bit value in IDLE,
// shifts for 8 cycles through the shared correction cells, then holds HUNDREDS/TENS/ONES
// with out_valid until out_ready.
module bcd_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int ITERS = WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    bcd_seq_ctrl_if.slave  bus
);
    import bcd_pkg::*;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [2:0]         cnt;

    logic [DIGIT_W-1:0] ones_corr;
    logic [DIGIT_W-1:0] tens_corr;
    logic [BCD_W-1:0]   corrected;

    logic               last_iter;

    bcd3 u_ones (
        .din  (bcd_sr[DIGIT_W-1:0]),
        .dout (ones_corr)
    );

    bcd3 u_tens (
        .din  (bcd_sr[2*DIGIT_W-1:DIGIT_W]),
        .dout (tens_corr)
    );

    // Hundreds never reaches 5 for an 8-bit operand, so it bypasses correction.
    assign corrected = {bcd_sr[BCD_W-1:2*DIGIT_W], tens_corr, ones_corr};
    assign last_iter = (cnt == 3'(ITERS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (last_iter)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_sr <= bus.in_data;
                        bcd_sr <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    // Top bit of corrected is dropped: hundreds stays within 0..2.
                    bcd_sr <= {corrected[BCD_W-2:0], bin_sr[WIDTH-1]};
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == SHIFT) || (state == DONE);

    assign bus.ONES      = bcd_sr[DIGIT_W-1:0];
    assign bus.TENS      = bcd_sr[2*DIGIT_W-1:DIGIT_W];
    assign bus.HUNDREDS  = bcd_sr[BCD_W-1:2*DIGIT_W];

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb/tb_bcd_seq_ctrl.sv - self-checking bench for bcd_seq_ctrl
module tb_bcd_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_seq_ctrl_if bus ();

    bcd_seq_ctrl #(.WIDTH(8), .ITERS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_h(input int v); return v / 100;        endfunction
    function automatic int ref_t(input int v); return (v / 10) % 10;  endfunction
    function automatic int ref_o(input int v); return v % 10;         endfunction

    task automatic chk_digits(input string tag, input int v);
        chk({tag, ".hundreds"}, int'(bus.HUNDREDS), ref_h(v));
        chk({tag, ".tens"},     int'(bus.TENS),     ref_t(v));
        chk({tag, ".ones"},     int'(bus.ONES),     ref_o(v));
    endtask

    // One full conversion starting from IDLE; stall = cycles out_ready stays low after out_valid.
    task automatic do_conv(input int v, input int stall, input bit hold_ready, input string tag);
        int n;
        bus.out_ready = hold_ready;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'(v);
        step();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'($urandom);
        chk({tag, ".busy_after_accept"}, int'(bus.busy), 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
            chk({tag, ".busy_vs_ready"}, int'(bus.busy), int'(!bus.in_ready));
        end
        chk({tag, ".latency"}, n, 8);
        chk_digits(tag, v);
        if (!hold_ready) begin
            for (int i = 0; i < stall; i++) begin
                bus.in_valid = 1'($urandom);
                step();
                chk({tag, ".stall_valid"}, int'(bus.out_valid), 1);
                chk({tag, ".stall_ready"}, int'(bus.in_ready), 0);
                chk_digits({tag, ".stall"}, v);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        step();
        chk({tag, ".release_valid"}, int'(bus.out_valid), 0);
        chk({tag, ".release_ready"}, int'(bus.in_ready), 1);
        chk({tag, ".release_busy"},  int'(bus.busy), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int   n;
        int   acc_cyc [2];
        int   hs_cyc  [2];
        int   res     [2];
        int   n_acc;
        int   n_hs;
        int   cyc;
        bit   acc;
        bit   hs;
        int   sample;

        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset.in_ready",  int'(bus.in_ready), 1);
        chk("reset.out_valid", int'(bus.out_valid), 0);
        chk("reset.busy",      int'(bus.busy), 0);
        chk_digits("reset", 0);

        // Max value with out_ready held high
        do_conv(255, 0, 1'b1, "ff");

        // Boundary values
        do_conv(0,   1, 1'b0, "b00");
        do_conv(99,  1, 1'b0, "b99");
        do_conv(100, 1, 1'b0, "b100");
        do_conv(199, 1, 1'b0, "b199");

        // Backpressure with a competing request held on the input
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7B;
        step();
        bus.in_data  = 8'h11;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp.latency", n, 8);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp.out_valid", int'(bus.out_valid), 1);
            chk("bp.in_ready",  int'(bus.in_ready), 0);
            chk_digits("bp", 123);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp.release_ready", int'(bus.in_ready), 1);
        chk("bp.release_valid", int'(bus.out_valid), 0);
        step();
        bus.in_valid = 1'b0;
        chk("bp.second_accept", int'(bus.busy), 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp.second_latency", n, 8);
        chk_digits("bp.second", 17);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Reset in the middle of a conversion
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.in_ready",  int'(bus.in_ready), 1);
        chk("midrst.out_valid", int'(bus.out_valid), 0);
        chk("midrst.busy",      int'(bus.busy), 0);
        chk_digits("midrst", 0);
        do_conv(42, 2, 1'b0, "after_rst");

        // Back-to-back with in_valid and out_ready held high
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h7B;
        bus.out_ready = 1'b1;
        n_acc = 0;
        n_hs  = 0;
        cyc   = 0;
        while (n_hs < 2 && cyc < 60) begin
            acc    = bus.in_ready && bus.in_valid;
            hs     = bus.out_valid && bus.out_ready;
            sample = int'(bus.HUNDREDS) * 100 + int'(bus.TENS) * 10 + int'(bus.ONES);
            step();
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                bus.in_data = 8'hC8;
            end
            if (hs) begin
                hs_cyc[n_hs] = cyc;
                res[n_hs]    = sample;
                n_hs++;
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b.handshakes", n_hs, 2);
        chk("b2b.accepts", n_acc, 2);
        if (n_hs == 2 && n_acc == 2) begin
            chk("b2b.result0", res[0], 123);
            chk("b2b.result1", res[1], 200);
            chk("b2b.turnaround", acc_cyc[1] - hs_cyc[0], 1);
            chk("b2b.period", acc_cyc[1] - acc_cyc[0], 10);
        end
        if (bus.busy) begin
            bus.out_ready = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 20) begin
                step();
                n++;
            end
            bus.out_ready = 1'b0;
        end
        chk("b2b.idle", int'(bus.in_ready), 1);

        // Exhaustive sweep with random output stalls
        for (int v = 0; v < 256; v++) begin
            do_conv(v, int'($urandom_range(0, 3)), 1'b0, "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_seq_ctrl.md
# bcd_seq_ctrl

Sequential binary-to-BCD conversion controller that performs shift-and-add-3 (double dabble) conversion one bit per clock on a shared correction datapath. It converts an 8-bit unsigned binary value into hundreds/tens/ones BCD digits. Valid/ready handshakes sit on both input and output. It is used where a single registered converter is shared by a display or reporting path, in place of an unrolled combinational converter tree.

## Interface
- WIDTH, 8, binary input width; only 8 is supported, and the digit widths below are fixed to it.
- ITERS, WIDTH, number of shift iterations per conversion; not to be overridden.

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  requester has a value on in_data
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  8  unsigned binary operand
- out_valid  out  1  ONES/TENS/HUNDREDS hold a finished result
- out_ready  in  1  consumer accepts the result
- ONES  out  4  BCD units digit
- TENS  out  4  BCD tens digit
- HUNDREDS  out  2  BCD hundreds digit, range 0..2
- busy  out  1  high in SHIFT or DONE

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Registers:**
  - bin_sr[7:0]: binary shift register.
  - bcd_sr[9:0] = {HUNDREDS, TENS, ONES}.
  - cnt[2:0]: iteration counter.
  - state.
- **IDLE:**
  - in_ready=1.
  - On in_valid && in_ready: bin_sr<=in_data, bcd_sr<=0, cnt<=0, state<=SHIFT.
- **SHIFT:** each cycle performs one iteration.
  - Correct: each of ONES and TENS gets +3 if the digit ≥5, else passes unchanged. HUNDREDS is never corrected.
  - Shift: bcd_sr <= {corrected[8:0], bin_sr[7]}; bin_sr <= bin_sr<<1.
  - cnt increments each cycle. The iteration with cnt==7 sets state<=DONE.
- **DONE:**
  - out_valid=1; bcd_sr and outputs are frozen.
  - On out_ready: state<=IDLE.
- **Output registers:** ONES/TENS/HUNDREDS are driven directly from bcd_sr. They are visible during SHIFT, but only meaningful while out_valid=1.
- **Handshake rules:**
  - in_ready is not asserted in DONE, even on the cycle out_ready is high. There is no same-cycle turnaround.
  - in_data is sampled only on the accept edge and may change afterwards.
  - in_valid is ignored outside IDLE.
- **Reset:**
  - rst high forces state=IDLE, bcd_sr=0, bin_sr=0, cnt=0. This aborts any conversion in progress, and the partial result is discarded.
  - Handshakes are ignored on cycles where rst=1.
- **Reset values:**
  - in_ready=1 (IDLE).
  - out_valid=0, busy=0.
  - ONES=0, TENS=0, HUNDREDS=0.

## Timing
- **Accept:** accept edge E0. Iterations occur on edges E1..E8. After E8, out_valid=1.
- **Latency:** 8 cycles from accept edge to out_valid.
- **Result hold:** the result is held for as long as out_ready stays low; there is no timeout.
- **Release:** on the edge where out_valid && out_ready, out_valid falls and in_ready rises.
- **Throughput:** minimum 10 cycles per conversion (accept, 8 shifts, 1 output-handshake cycle).
- **Combinational paths:** in_ready, out_valid and busy are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- **Per-cycle datapath:** one level of add-3 correction plus a shift. The critical path is one correction cell plus the mux.

## Structure
- **Package bcd_pkg:**
  - state enum {IDLE, SHIFT, DONE}.
  - ITERS=8.
  - DIGIT_W=4, HUND_W=2.
  - Correction threshold constant 5 and offset 3.
- **Sub-module:** the team's existing bcd3 add-3 correction cell, two instances: ONES digit and TENS digit.
- **Controller:** FSM, counter and shift registers are in bcd_seq_ctrl itself.
- **Size:** target 150–250 lines of RTL.

## Test plan
- Reset, then in_data=0xFF with out_ready=1 → out_valid rises exactly 8 cycles after accept with HUNDREDS=2, TENS=5, ONES=5. in_ready returns 1 the cycle after the output handshake.
- Boundary values, each in turn:
  - 0x00 → 0,0,0
  - 0x63 (99) → 0,9,9
  - 0x64 (100) → 1,0,0
  - 0xC7 (199) → 1,9,9
- Backpressure: convert 0x7B (123), hold out_ready=0 for 6 cycles after out_valid, with in_valid=1 and in_data=0x11 throughout → outputs stay 1,2,3 and stable, in_ready=0, and 0x11 is not accepted until the cycle after out_ready.
- Reset mid-conversion: assert rst for 1 cycle after the 4th iteration of 0xFF → next cycle IDLE, all outputs 0, out_valid=0. A following 0x2A (42) yields 0,4,2 with no residue from the aborted run.
- Back-to-back: in_valid held high with 0x7B then 0xC8, out_ready=1 → results 1,2,3 then 2,0,0. The second accept occurs exactly 1 cycle after the first output handshake; conversion period 10 cycles.
- Exhaustive: all 256 inputs with random out_ready stalls, compared against a behavioural divide-by-10 model. Checks:
  - zero mismatches;
  - busy == !in_ready every cycle.
